// File: rtl/filter_pkg.sv
// filter_pkg: shared types and constants for the glitch-filter scan sequencer
package filter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_DWELL, ST_DONE} state_t;
  localparam int NPHASE = 4;
  localparam int CNT_W = 8;
  localparam logic [2*NPHASE-1:0] PHASE_AB = 8'b11_10_01_00;
  function automatic logic [1:0] ab_of(input logic [1:0] p);
    return PHASE_AB[{p, 1'b0} +: 2];
  endfunction
endpackage

// File: rtl/fault_sampler.sv
// fault_sampler: sticky per-phase record of X sampled low while enabled
module fault_sampler
  import filter_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              clear,
  input  logic              smp_en,
  input  logic [1:0]        phase,
  input  logic              x,
  output logic [NPHASE-1:0] mask
);
  logic [NPHASE-1:0] mask_q, mask_d;
  always_comb mask_d = clear ? '0 : (smp_en && !x) ? (mask_q | (NPHASE'(1) << phase)) : mask_q;
  always_ff @(posedge CLK or posedge RST)
    if (RST) mask_q <= '0;
    else mask_q <= mask_d;
  assign mask = mask_q;
endmodule

// File: rtl/filter_scan_ctrl.sv
// filter_scan_ctrl: steps the filter's A/B select through all phases,
// ignores X while it settles, then records X faults during a dwell window.
module filter_scan_ctrl
  import filter_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int DWELL  = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Start,
  input  logic       Abort,
  input  logic       X,
  output logic       A,
  output logic       B,
  output logic       Busy,
  output logic       Done,
  output logic [3:0] FaultMask,
  output logic       Pass
);
  localparam logic [CNT_W-1:0] SET_LD = CNT_W'(SETTLE - 1);
  localparam logic [CNT_W-1:0] DW_LD  = CNT_W'(DWELL - 1);
  state_t state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pass_q, pass_d;
  logic clr;
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE:
        if (Start) begin
          state_d = ST_SETTLE;
          phase_d = '0;
          cnt_d   = SET_LD;
          pass_d  = 1'b0;
          clr     = 1'b1;
        end
      ST_SETTLE:
        if (Abort) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end else if (cnt_q == '0) begin
          state_d = ST_DWELL;
          cnt_d   = DW_LD;
        end else cnt_d = cnt_q - 1'b1;
      ST_DWELL:
        if (Abort) begin
          state_d = ST_IDLE;
          pass_d  = 1'b0;
        end else if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        else if (phase_q == 2'(NPHASE - 1)) begin
          state_d = ST_DONE;
          // the final phase's last X sample lands on this same edge
          pass_d  = (FaultMask == '0) && X;
        end else begin
          state_d = ST_SETTLE;
          phase_d = phase_q + 2'd1;
          cnt_d   = SET_LD;
        end
      ST_DONE: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      cnt_q   <= '0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  fault_sampler u_smp (
    .CLK    (CLK),
    .RST    (RST),
    .clear  (clr),
    .smp_en (state_q == ST_DWELL),
    .phase  (phase_q),
    .x      (X),
    .mask   (FaultMask)
  );
  assign Busy   = (state_q == ST_SETTLE) || (state_q == ST_DWELL);
  assign Done   = state_q == ST_DONE;
  assign {A, B} = Busy ? ab_of(phase_q) : 2'b00;
  assign Pass   = pass_q;
endmodule

// File: tb/tb_filter_scan_ctrl.sv
// tb_filter_scan_ctrl: directed scans with a scoreboard of expected mask/pass results
module tb_filter_scan_ctrl;
  logic CLK = 1'b0, RST = 1'b1, Start = 1'b0, Abort = 1'b0, X = 1'b1;
  logic a0, b0, busy0, done0, pass0, a1, b1, busy1, done1, pass1;
  logic [3:0] mask0, mask1;
  int sel = 0;
  int compared = 0, mismatched = 0;
  logic [4:0] sb[$];

  always #5 CLK = ~CLK;

  filter_scan_ctrl #(.SETTLE(2), .DWELL(8)) u0 (
    .CLK(CLK), .RST(RST), .Start(Start), .Abort(Abort), .X(X),
    .A(a0), .B(b0), .Busy(busy0), .Done(done0), .FaultMask(mask0), .Pass(pass0));
  filter_scan_ctrl #(.SETTLE(1), .DWELL(1)) u1 (
    .CLK(CLK), .RST(RST), .Start(Start), .Abort(Abort), .X(X),
    .A(a1), .B(b1), .Busy(busy1), .Done(done1), .FaultMask(mask1), .Pass(pass1));

  wire       o_busy = sel != 0 ? busy1 : busy0;
  wire       o_done = sel != 0 ? done1 : done0;
  wire       o_pass = sel != 0 ? pass1 : pass0;
  wire [1:0] o_ab   = sel != 0 ? {a1, b1} : {a0, b0};
  wire [3:0] o_mask = sel != 0 ? mask1 : mask0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic xval(input int mode, input int ph, input int off, input int s, input int fp, input int fd);
    if (mode == 1) return !(ph == fp && off >= s && off - s == fd);
    if (mode == 2) return off >= s;
    if (mode == 3) return !(ph == 0 && off >= s);
    return 1'b1;
  endfunction

  task automatic pop_chk(input string tag);
    logic [4:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_mask"}, o_mask, e[4:1]);
    chk({tag, "_pass"}, o_pass, e[0]);
  endtask

  // Called at a negedge with the selected DUT in IDLE; abort_at/rst_at < 0 disables them.
  task automatic scan(input int s_sel, input int mode, input int fp, input int fd,
                      input int abort_at, input int rst_at, input logic [3:0] exp_mask,
                      input logic exp_pass, input bit hold);
    int s, d, total, ph, off;
    sel = s_sel;
    s = s_sel != 0 ? 1 : 2;
    d = s_sel != 0 ? 1 : 8;
    total = 4 * (s + d);
    sb.push_back({exp_mask, exp_pass});
    Start = 1'b1;
    @(negedge CLK);
    if (!hold) Start = 1'b0;
    chk("start_clr_mask", o_mask, 4'b0000);
    chk("start_clr_pass", o_pass, 1'b0);
    for (int c = 0; c < total; c++) begin
      ph = c / (s + d);
      off = c % (s + d);
      chk($sformatf("busy_c%0d", c), o_busy, 1'b1);
      chk($sformatf("ab_c%0d", c), o_ab, ph[1:0]);
      chk($sformatf("done_c%0d", c), o_done, 1'b0);
      X = xval(mode, ph, off, s, fp, fd);
      if (!hold) Start = (c == 5);
      Abort = (c == abort_at);
      if (c == rst_at) begin
        #1 RST = 1'b1;
        #1;
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_ab", o_ab, 2'b00);
        chk("rst_done", o_done, 1'b0);
        pop_chk("rst");
        #1 RST = 1'b0;
        X = 1'b1;
        @(negedge CLK);
        chk("post_rst_busy", o_busy, 1'b0);
        chk("post_rst_done", o_done, 1'b0);
        return;
      end
      @(negedge CLK);
      if (c == abort_at) begin
        Abort = 1'b0;
        X = 1'b1;
        chk("abort_busy", o_busy, 1'b0);
        chk("abort_ab", o_ab, 2'b00);
        chk("abort_done", o_done, 1'b0);
        pop_chk("abort");
        return;
      end
    end
    X = 1'b1;
    chk("done_pulse", o_done, 1'b1);
    chk("done_busy", o_busy, 1'b0);
    chk("done_ab", o_ab, 2'b00);
    pop_chk("done");
    @(negedge CLK);
    chk("idle_done", o_done, 1'b0);
    chk("idle_busy", o_busy, 1'b0);
    chk("idle_mask_held", o_mask, exp_mask);
    chk("idle_pass_held", o_pass, exp_pass);
  endtask

  initial begin
    #2;
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_done", o_done, 1'b0);
    chk("reset_ab", o_ab, 2'b00);
    chk("reset_mask", o_mask, 4'b0000);
    chk("reset_pass", o_pass, 1'b0);
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    chk("idle_busy_pre", o_busy, 1'b0);
    scan(0, 0, 0, 0, -1, -1, 4'b0000, 1'b1, 1'b0);
    scan(0, 1, 2, 4, -1, -1, 4'b0100, 1'b0, 1'b0);
    scan(0, 2, 0, 0, -1, -1, 4'b0000, 1'b1, 1'b0);
    scan(0, 3, 0, 0, 15, -1, 4'b0001, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    chk("abort_no_done", o_done, 1'b0);
    chk("abort_mask_kept", o_mask, 4'b0001);
    scan(0, 0, 0, 0, -1, 35, 4'b0000, 1'b0, 1'b0);
    scan(0, 0, 0, 0, -1, -1, 4'b0000, 1'b1, 1'b0);
    repeat (50) @(negedge CLK);
    scan(1, 1, 2, 0, -1, -1, 4'b0100, 1'b0, 1'b1);
    scan(1, 0, 0, 0, -1, -1, 4'b0000, 1'b1, 1'b1);
    Start = 1'b0;
    repeat (2) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/filter_scan_ctrl.md
# filter_scan_ctrl

Clocked sequencer for the four-channel glitch filter (four X-watching RS latches gated by A, B and their complements). It steps the filter's (A,B) select through all four combinations, waits a settle window, watches X for a dwell window per combination, and reports a 4-bit per-phase fault mask with a start/busy/done handshake. It sits between the test or control logic and the filter: it drives the filter's A/B and monitors the same X net.

## Interface
- SETTLE, default 2: cycles per phase after A/B change during which X is ignored; legal range 1..255.
- DWELL, default 8: cycles per phase during which X is sampled; legal range 1..255.
- CLK  in  1  single clock; all state updates on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- Start  in  1  run request; accepted only in IDLE.
- Abort  in  1  cancel request; effective only while Busy.
- X  in  1  filtered signal under watch; active-low fault (X=0 is a fault).
- A  out  1  filter select A, registered.
- B  out  1  filter select B, registered.
- Busy  out  1  high in SETTLE and DWELL states.
- Done  out  1  one-cycle pulse at completion of a full run.
- FaultMask  out  4  bit p set if X=0 was sampled during DWELL of phase p.
- Pass  out  1  1 when the last completed run had FaultMask==0.

## Operation
- States: IDLE, SETTLE, DWELL, DONE.
- Phase index p = 0..3, with {A,B} = p in order 00, 01, 10, 11. A=B=0 in IDLE and DONE.
- IDLE + Start: go to SETTLE with p=0, clear FaultMask to 0, clear Pass, and load the counter.
- SETTLE: occupies exactly SETTLE cycles and ignores X. It then moves to DWELL.
- DWELL: occupies exactly DWELL cycles. Every cycle, X=0 sets FaultMask[p] (sticky). After the last cycle:
  - if p<3, increment p and return to SETTLE;
  - if p==3, go to DONE.
- DONE: one cycle. Done=1, Busy=0, and Pass = (FaultMask==0) is registered. The next state is IDLE.
- Abort while Busy: the next state is IDLE and A=B=0. There is no Done pulse. FaultMask keeps its partial contents and Pass=0. Abort has priority over any phase advance.
- Ignored inputs:
  - Abort in IDLE or DONE is ignored.
  - Start outside IDLE is ignored.
  - Start held high restarts from IDLE on the next edge, and FaultMask is cleared at that restart.
- Reset values: state IDLE, p=0, counter 0, A=0, B=0, Busy=0, Done=0, FaultMask=0, Pass=0. These apply immediately, without waiting for a clock edge.
- Counter width: 8 bits, counting down, with the load value selected by state.

## Timing
- All outputs are registered; there are no combinational paths from input to output.
- Start sampled high at edge k causes Busy=1, A=B=0 after edge k.
- Each phase lasts SETTLE+DWELL cycles, so Busy is high for exactly 4*(SETTLE+DWELL) cycles.
- Done is high for the single cycle after edge k+4*(SETTLE+DWELL). FaultMask and Pass are valid from that cycle and held until the next accepted Start.
- A/B change on the same edge that enters SETTLE of the new phase.
- Start to Done latency with default parameters: 40 cycles busy, plus Done in cycle 41.
- X is sampled at every edge where the state is DWELL. A low pulse shorter than one cycle between edges is not guaranteed to be detected.
- Abort sampled at edge j gives Busy=0 and state IDLE after edge j.
- RST asserted mid-run clears all outputs asynchronously. After deassertion the block idles until Start.

## Structure
- Shared package filter_pkg holds:
  - the state enum (IDLE, SETTLE, DWELL, DONE);
  - NPHASE=4;
  - the phase-to-{A,B} encoding constant;
  - the counter width constant (8).
- One sub-module, fault_sampler, holds the 4-bit sticky mask. Its inputs are clear, sample enable, phase index and X; it resets asynchronously on RST.
- The FSM, counter and phase register live in filter_scan_ctrl.

## Test plan
Unless stated, SETTLE=2 and DWELL=8.
- X held 1, Start pulse → Busy high 40 cycles; {A,B}=00,01,10,11 for 10 cycles each; one-cycle Done; FaultMask=4'b0000, Pass=1.
- X=0 for one cycle at the 5th DWELL cycle of phase 2 → FaultMask=4'b0100, Pass=0; A/B sequence unchanged.
- X=0 in both SETTLE cycles of every phase, 1 otherwise → FaultMask=0, Pass=1.
- X=0 in DWELL of phase 0, then Abort at cycle 15 (phase 1) → Busy=0 and A=B=0 next cycle; no Done; FaultMask=4'b0001, Pass=0; a Start pulse during the run is ignored.
- RST pulsed during phase 3 between edges → all outputs 0 immediately; no Done; a subsequent Start runs a full 40-cycle scan.
- Start held high across two runs → second run begins one IDLE cycle after Done; FaultMask clears at the restart; SETTLE=1, DWELL=1 run gives Busy=8 cycles.
